time_set_ctrl: RTL and testbench

- Front-panel time-setting controller for the digital clock.
- Sequences the hour, minute and second BCD counters through a setting session: it captures the current time, lets the user edit one field at a time with two keys, then loads the edited values through the counters' preset interface (pre_* value plus PE strobe).
- Sits between the key inputs and the hour/min/sec counters. It also gates the seconds tick while a session is active.

---
 rtl/time_set_ctrl.sv | 167 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: captures the running time, lets the user
// edit hour/min/sec with mode/inc keys, then presets the counters via PE strobes.
module time_set_ctrl #(
    parameter int         PE_HOLD     = 4,
    parameter int         TIMEOUT_CYC = 1000,
    parameter logic [7:0] HOUR_MAX    = 8'h23
) (
    input  logic       clk,
    input  logic       CR,
    input  logic       key_mode,
    input  logic       key_inc,
    input  logic [7:0] show_hour,
    input  logic [7:0] show_min,
    input  logic [7:0] show_sec,
    output logic [7:0] pre_hour,
    output logic [7:0] pre_min,
    output logic [7:0] pre_sec,
    output logic       PE_hour,
    output logic       PE_min,
    output logic       PE_sec,
    output logic       run_en,
    output logic [1:0] blink_sel
);

    localparam int         CNT_TOP  = (TIMEOUT_CYC > PE_HOLD) ? TIMEOUT_CYC : PE_HOLD;
    localparam int         CW       = $clog2(CNT_TOP + 1);
    localparam logic [7:0] MS_MAX   = 8'h59;
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] PE_LAST  = CW'(PE_HOLD - 1);

    typedef enum logic [2:0] {
        S_RUN,
        S_SET_HR,
        S_SET_MIN,
        S_SET_SEC,
        S_COMMIT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    hour_n, min_n, sec_n;
    logic          pe;
    logic [1:0]    mode_s, inc_s;
    logic          mode_d, inc_d;
    logic          mode_p, inc_p;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v >= max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Captured values must be legal BCD within range, otherwise they start at zero.
    function automatic logic [7:0] bcd_clean(input logic [7:0] v, input logic [7:0] max_v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v)
            return 8'h00;
        return v;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            mode_s <= '0;
            inc_s  <= '0;
            mode_d <= 1'b0;
            inc_d  <= 1'b0;
            mode_p <= 1'b0;
            inc_p  <= 1'b0;
        end else begin
            mode_s <= {mode_s[0], key_mode};
            inc_s  <= {inc_s[0], key_inc};
            mode_d <= mode_s[1];
            inc_d  <= inc_s[1];
            mode_p <= mode_s[1] & ~mode_d;
            inc_p  <= inc_s[1] & ~inc_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hour_n  = pre_hour;
        min_n   = pre_min;
        sec_n   = pre_sec;
        case (state)
            S_RUN: begin
                cnt_n = '0;
                if (mode_p) begin
                    hour_n  = bcd_clean(show_hour, HOUR_MAX);
                    min_n   = bcd_clean(show_min, MS_MAX);
                    sec_n   = bcd_clean(show_sec, MS_MAX);
                    state_n = S_SET_HR;
                end
            end
            S_SET_HR, S_SET_MIN, S_SET_SEC: begin
                if (mode_p) begin
                    cnt_n = '0;
                    case (state)
                        S_SET_HR:  state_n = S_SET_MIN;
                        S_SET_MIN: state_n = S_SET_SEC;
                        default:   state_n = S_COMMIT;
                    endcase
                end else if (inc_p) begin
                    cnt_n = '0;
                    case (state)
                        S_SET_HR:  hour_n = bcd_inc(pre_hour, HOUR_MAX);
                        S_SET_MIN: min_n  = bcd_inc(pre_min, MS_MAX);
                        default:   sec_n  = bcd_inc(pre_sec, MS_MAX);
                    endcase
                end else if (cnt == TO_LAST) begin
                    cnt_n   = '0;
                    state_n = S_RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_COMMIT: begin
                if (cnt == PE_LAST) begin
                    cnt_n   = '0;
                    state_n = S_RUN;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = S_RUN;
            end
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            state     <= S_RUN;
            cnt       <= '0;
            pre_hour  <= 8'h00;
            pre_min   <= 8'h00;
            pre_sec   <= 8'h00;
            pe        <= 1'b0;
            run_en    <= 1'b1;
            blink_sel <= 2'd0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            pre_hour <= hour_n;
            pre_min  <= min_n;
            pre_sec  <= sec_n;
            pe       <= (state_n == S_COMMIT);
            run_en   <= (state_n == S_RUN);
            case (state_n)
                S_SET_HR:  blink_sel <= 2'd1;
                S_SET_MIN: blink_sel <= 2'd2;
                S_SET_SEC: blink_sel <= 2'd3;
                default:   blink_sel <= 2'd0;
            endcase
        end
    end

    assign PE_hour = pe;
    assign PE_min  = pe;
    assign PE_sec  = pe;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: a session-level model pushes expected output
// snapshots; a monitor pops one each time the DUT's registered outputs change.
module tb_time_set_ctrl;

    localparam int PE_HOLD = 4;
    localparam int TIMEOUT = 1000;

    logic       clk;
    logic       CR;
    logic       key_mode, key_inc;
    logic [7:0] show_hour, show_min, show_sec;
    logic [7:0] pre_hour, pre_min, pre_sec;
    logic       PE_hour, PE_min, PE_sec;
    logic       run_en;
    logic [1:0] blink_sel;

    time_set_ctrl #(.PE_HOLD(PE_HOLD), .TIMEOUT_CYC(TIMEOUT), .HOUR_MAX(8'h23)) dut (
        .clk(clk), .CR(CR), .key_mode(key_mode), .key_inc(key_inc),
        .show_hour(show_hour), .show_min(show_min), .show_sec(show_sec),
        .pre_hour(pre_hour), .pre_min(pre_min), .pre_sec(pre_sec),
        .PE_hour(PE_hour), .PE_min(PE_min), .PE_sec(PE_sec),
        .run_en(run_en), .blink_sel(blink_sel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Model: field 0 = running, 1..3 = editing hour/min/sec; values kept as BCD bytes.
    int          m_field = 0;
    logic [7:0]  m_pre[3];
    logic [29:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int max_of(input int f);
        return (f == 0) ? 23 : 59;
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic [7:0] model_inc(input logic [7:0] v, input int f);
        int n;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        return to_bcd((n + 1) % (max_of(f) + 1));
    endfunction

    function automatic logic [7:0] model_capture(input logic [7:0] v, input int f);
        int n;
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
            return 8'h00;
        n = int'(v[7:4]) * 10 + int'(v[3:0]);
        return (n > max_of(f)) ? 8'h00 : v;
    endfunction

    function automatic logic [29:0] snap(input logic [1:0] b, input logic r, input logic [2:0] pe);
        return {b, r, pe, m_pre[0], m_pre[1], m_pre[2]};
    endfunction

    // Monitor: every change of the output tuple must match the next expected snapshot.
    logic [29:0] cur, last;
    bit          have_last = 0;
    int          pe_cnt = 0;
    always @(negedge clk) begin
        cur = {blink_sel, run_en, PE_hour, PE_min, PE_sec, pre_hour, pre_min, pre_sec};
        if (!have_last || cur !== last) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_change: got %h expected no change at %0t", cur, $time);
            end else begin
                check("outputs", 32'(cur), 32'(exp_q.pop_front()));
            end
            last      = cur;
            have_last = 1;
        end
        if (PE_hour) begin
            pe_cnt++;
        end else if (pe_cnt != 0) begin
            check("pe_length", pe_cnt, PE_HOLD);
            pe_cnt = 0;
        end
    end

    task automatic model_press(input bit m, input bit i);
        if (m) begin
            if (m_field == 0) begin
                m_pre[0] = model_capture(show_hour, 0);
                m_pre[1] = model_capture(show_min, 1);
                m_pre[2] = model_capture(show_sec, 2);
                m_field  = 1;
                exp_q.push_back(snap(2'd1, 1'b0, 3'b000));
            end else if (m_field < 3) begin
                m_field++;
                exp_q.push_back(snap(2'(m_field), 1'b0, 3'b000));
            end else begin
                m_field = 0;
                exp_q.push_back(snap(2'd0, 1'b0, 3'b111));
                exp_q.push_back(snap(2'd0, 1'b1, 3'b000));
            end
        end else if (i && m_field != 0) begin
            m_pre[m_field-1] = model_inc(m_pre[m_field-1], m_field - 1);
            exp_q.push_back(snap(2'(m_field), 1'b0, 3'b000));
        end
    endtask

    task automatic press(input bit m, input bit i);
        @(negedge clk);
        model_press(m, i);
        key_mode = m;
        key_inc  = i;
        repeat (3) @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic set_show(input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
        @(negedge clk);
        show_hour = h;
        show_min  = mi;
        show_sec  = s;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Final mode press from SET_SEC with extra key activity landing inside COMMIT.
    task automatic commit_with_noise();
        @(negedge clk);
        model_press(1'b1, 1'b0);
        key_mode = 1'b1;
        repeat (2) @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b1;
        @(negedge clk);
        key_mode = 1'b1;
        repeat (3) @(negedge clk);
        key_mode = 1'b0;
        key_inc  = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        CR        = 1'b1;
        key_mode  = 1'b0;
        key_inc   = 1'b0;
        show_hour = 8'h00;
        show_min  = 8'h00;
        show_sec  = 8'h00;
        m_pre[0]  = 8'h00;
        m_pre[1]  = 8'h00;
        m_pre[2]  = 8'h00;
        exp_q.push_back(snap(2'd0, 1'b1, 3'b000));
        repeat (3) @(negedge clk);
        check("reset_run_en", run_en, 1);
        check("reset_pre", {pre_hour, pre_min, pre_sec}, 0);
        CR = 1'b0;
        repeat (2) @(negedge clk);

        // Capture and commit 12:34:56 unchanged
        set_show(8'h12, 8'h34, 8'h56);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        wait_drain();

        // Wrap from 23:59:59, and inc while running has no effect
        press(1'b0, 1'b1);
        set_show(8'h23, 8'h59, 8'h59);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("wrap_pre", {pre_hour, pre_min, pre_sec}, 0);
        press(1'b1, 1'b0);
        wait_drain();

        // Hour 09 -> 10, invalid min capture, simultaneous keys in SET_MIN at 07
        set_show(8'h09, 8'h7A, 8'h3F);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("hour_09_to_10", pre_hour, 8'h10);
        check("invalid_min", pre_min, 8'h00);
        press(1'b1, 1'b0);
        repeat (7) press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        check("simul_min_kept", pre_min, 8'h07);
        check("simul_blink", blink_sel, 2'd3);
        commit_with_noise();
        wait_drain();

        // Timeout: idle in SET_HR aborts to RUN, no PE pulse, values kept
        set_show(8'h24, 8'h05, 8'h60);
        press(1'b1, 1'b0);
        m_field = 0;
        exp_q.push_back(snap(2'd0, 1'b1, 3'b000));
        repeat (900) @(negedge clk);
        check("timeout_not_early", run_en, 0);
        repeat (200) @(negedge clk);
        wait_drain();
        check("timeout_pre", {pre_hour, pre_min, pre_sec}, 32'h00_05_00);

        // Randomized sessions
        for (int s = 0; s < 14; s++) begin
            if ($urandom_range(0, 3) == 0)
                set_show(8'($urandom), 8'($urandom), 8'($urandom));
            else
                set_show(to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                         to_bcd($urandom_range(0, 59)));
            press(1'b1, 1'b0);
            for (int f = 0; f < 3; f++) begin
                int n;
                n = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 30) : $urandom_range(0, 3);
                for (int k = 0; k < n; k++)
                    press(1'b0, 1'b1);
                press(1'b1, $urandom_range(0, 2) == 0);
            end
            wait_drain();
        end

        // Asynchronous reset in the middle of SET_MIN
        set_show(8'h11, 8'h22, 8'h33);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        wait_drain();
        @(posedge clk);
        #2;
        m_field  = 0;
        m_pre[0] = 8'h00;
        m_pre[1] = 8'h00;
        m_pre[2] = 8'h00;
        exp_q.push_back(snap(2'd0, 1'b1, 3'b000));
        CR = 1'b1;
        #1;
        check("async_reset_outputs", {blink_sel, run_en, PE_hour, PE_min, PE_sec},
              {2'd0, 1'b1, 3'b000});
        check("async_reset_pre", {pre_hour, pre_min, pre_sec}, 0);
        repeat (2) @(negedge clk);
        CR = 1'b0;
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
